writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of pending write-buffer entries; only the value 2 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port inValid, input, 1 bit: the MEM stage offers a result this cycle.
REQ-005 SHALL have port inReady, output, 1 bit: the stage can accept an offer this cycle.
REQ-006 SHALL have ports inRegWrite (input, 1 bit) and inDest (input, 5 bits): destination write request and register index.
REQ-007 SHALL have port inMemToReg, input, 1 bit: 1 selects load data, 0 selects the ALU result.
REQ-008 SHALL have ports inLoadSize (input, 2 bits; 00 word, 01 half, 10 byte, 11 treated as word), inLoadSigned (input, 1 bit) and inByteOffset (input, 2 bits).
REQ-009 SHALL have ports inAluResult (input, 32 bits) and inMemData (input, 32 bits, little-endian word).
REQ-010 SHALL have port flush, input, 1 bit: discard all pending writes.
REQ-011 SHALL have port portGrant, input, 1 bit: the register bank accepts the presented write this cycle.
REQ-012 SHALL have port writeEnable, output, 1 bit, active low: a write is presented to the 32-bit register bank.
REQ-013 SHALL have ports writeAddr (output, 5 bits) and writeData (output, 32 bits).
REQ-014 SHALL have port count, output, 2 bits: number of buffered writes, 0..2.

Function
REQ-015 SHALL accept an offer when inValid=1 and inReady=1 on a rising edge.
REQ-016 SHALL drive inReady = 1 when count<2 and flush=0, and 0 otherwise.
REQ-017 SHALL discard an accepted offer with inRegWrite=0 or inDest=0 without enqueueing it.
REQ-018 SHALL compute the result at enqueue time: the ALU result when inMemToReg=0, otherwise the extracted load data.
REQ-019 SHALL extract a byte at bits [8*off+7:8*off], where off = inByteOffset.
REQ-020 SHALL extract a half at bits [15:0] when inByteOffset[1]=0 and [31:16] when inByteOffset[1]=1; inByteOffset[0] SHALL be ignored for halves.
REQ-021 SHALL sign-extend byte and half loads when inLoadSigned=1 and zero-extend them otherwise; word loads SHALL pass unchanged.
REQ-022 SHALL keep entries in a 2-entry FIFO ordered by acceptance; the head is the oldest entry.
REQ-023 SHALL drive writeEnable=0, writeAddr=head dest and writeData=head data when count>0.
REQ-024 SHALL drive writeEnable=1, writeAddr=0 and writeData=0 when count=0.
REQ-025 SHALL pop the head on an edge where writeEnable=0 and portGrant=1; without portGrant the head SHALL be held unchanged indefinitely.
REQ-026 SHALL handle a push and a pop on the same edge with count unchanged and FIFO order preserved.
REQ-027 SHALL make an offer accepted into an empty buffer at edge N visible on the write outputs in the cycle after edge N (latency 1).
REQ-028 SHALL give flush=1 priority over push and pop: count becomes 0 at the next edge, no pop occurs, and an offer presented that cycle is not accepted.
REQ-029 SHALL include a successive write to the same dest as a separate entry; entries SHALL NOT be merged.

Reset
REQ-030 SHALL, while rst=1 at an edge, set count=0 and clear all entries; rst SHALL take priority over flush, push and pop.
REQ-031 SHALL, after reset, present writeEnable=1, writeAddr=0, writeData=0, count=0 and inReady=1 (with flush=0).
REQ-032 SHALL, on reset asserted mid-operation, lose buffered writes with no partial or extra writeEnable pulse.

Verification
REQ-033 SHALL be verified with: offer dest=5, ALU 0x12345678, portGrant=1 -> one cycle of writeEnable=0, addr 5, data 0x12345678, then count=0.
REQ-034 SHALL be verified with: load byte, signed, offset 3, mem 0x80FF_0000 -> data 0xFFFFFF80; same unsigned -> 0x00000080; half signed offset 2 -> 0xFFFF80FF.
REQ-035 SHALL be verified with: portGrant=0, offers to dest 1, 2, 3 -> count=2, inReady=0, third offer stalls; then portGrant=1 -> writes 1, 2, 3 in order.
REQ-036 SHALL be verified with: count=1, simultaneous offer and grant -> count stays 1 and the new entry is written the next cycle.
REQ-037 SHALL be verified with: count=2, flush=1 with inValid=1 -> count=0, writeEnable=1, and the offer is not accepted.
REQ-038 SHALL be verified with: offers with dest=0 or inRegWrite=0 -> accepted (inReady=1) and writeEnable remains 1.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: extracts load data, buffers up to two register writes in
// acceptance order, and presents the oldest one to the register bank.
module writeback_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic        inRegWrite,
    input  logic [4:0]  inDest,
    input  logic        inMemToReg,
    input  logic [1:0]  inLoadSize,
    input  logic        inLoadSigned,
    input  logic [1:0]  inByteOffset,
    input  logic [31:0] inAluResult,
    input  logic [31:0] inMemData,
    input  logic        flush,
    input  logic        portGrant,
    output logic        writeEnable,
    output logic [4:0]  writeAddr,
    output logic [31:0] writeData,
    output logic [1:0]  count
);

    localparam int unsigned RegW  = 5;
    localparam int unsigned DataW = 32;
    localparam int unsigned CntW  = 2;

    // Slot 0 is always the head; slot 1 is only valid when two entries are held.
    logic [CntW-1:0]  countQ, countNext;
    logic [RegW-1:0]  dest0Q, dest1Q, dest0Next, dest1Next;
    logic [DataW-1:0] data0Q, data1Q, data0Next, data1Next;

    logic [7:0]       byteSel;
    logic [15:0]      halfSel;
    logic [DataW-1:0] loadValue;
    logic [DataW-1:0] resultValue;
    logic             pushAccept;
    logic             pushKeep;
    logic             popHead;

    // Load data extraction and result selection, done at enqueue time.
    always_comb begin
        byteSel = 8'(inMemData >> {inByteOffset, 3'b000});
        halfSel = inByteOffset[1] ? inMemData[31:16] : inMemData[15:0];
        case (inLoadSize)
            2'b10:   loadValue = {{24{inLoadSigned & byteSel[7]}}, byteSel};
            2'b01:   loadValue = {{16{inLoadSigned & halfSel[15]}}, halfSel};
            default: loadValue = inMemData;
        endcase
        resultValue = inMemToReg ? loadValue : inAluResult;
    end

    assign inReady    = (countQ < CntW'(DEPTH)) && !flush;
    assign pushAccept = inValid && inReady;
    assign pushKeep   = pushAccept && inRegWrite && (inDest != '0);
    assign popHead    = (countQ != '0) && portGrant && !flush;

    // FIFO next-state: flush clears everything, otherwise push/pop with shift.
    always_comb begin
        countNext = countQ;
        dest0Next = dest0Q;
        dest1Next = dest1Q;
        data0Next = data0Q;
        data1Next = data1Q;
        if (flush) begin
            countNext = '0;
            dest0Next = '0;
            dest1Next = '0;
            data0Next = '0;
            data1Next = '0;
        end else begin
            case ({pushKeep, popHead})
                2'b11: begin
                    if (countQ == CntW'(1)) begin
                        dest0Next = inDest;
                        data0Next = resultValue;
                    end else begin
                        dest0Next = dest1Q;
                        data0Next = data1Q;
                        dest1Next = inDest;
                        data1Next = resultValue;
                    end
                end
                2'b10: begin
                    if (countQ == '0) begin
                        dest0Next = inDest;
                        data0Next = resultValue;
                    end else begin
                        dest1Next = inDest;
                        data1Next = resultValue;
                    end
                    countNext = countQ + CntW'(1);
                end
                2'b01: begin
                    dest0Next = dest1Q;
                    data0Next = data1Q;
                    dest1Next = '0;
                    data1Next = '0;
                    countNext = countQ - CntW'(1);
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            countQ <= '0;
            dest0Q <= '0;
            dest1Q <= '0;
            data0Q <= '0;
            data1Q <= '0;
        end else begin
            countQ <= countNext;
            dest0Q <= dest0Next;
            dest1Q <= dest1Next;
            data0Q <= data0Next;
            data1Q <= data1Next;
        end
    end

    // Register bank port driven straight from the head slot; idle values when empty.
    always_comb begin
        writeEnable = (countQ == '0);
        writeAddr   = (countQ != '0) ? dest0Q : '0;
        writeData   = (countQ != '0) ? data0Q : '0;
    end

    assign count = countQ;

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic        inRegWrite;
    logic [4:0]  inDest;
    logic        inMemToReg;
    logic [1:0]  inLoadSize;
    logic        inLoadSigned;
    logic [1:0]  inByteOffset;
    logic [31:0] inAluResult;
    logic [31:0] inMemData;
    logic        flush;
    logic        portGrant;
    logic        writeEnable;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic [1:0]  count;

    int checkCount = 0;
    int failCount  = 0;

    logic [4:0]  modelDest[$];
    logic [31:0] modelData[$];

    writeback_stage #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inReady(inReady),
        .inRegWrite(inRegWrite), .inDest(inDest),
        .inMemToReg(inMemToReg), .inLoadSize(inLoadSize),
        .inLoadSigned(inLoadSigned), .inByteOffset(inByteOffset),
        .inAluResult(inAluResult), .inMemData(inMemData),
        .flush(flush), .portGrant(portGrant),
        .writeEnable(writeEnable), .writeAddr(writeAddr),
        .writeData(writeData), .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Architectural load result from the size/sign/offset rules.
    function automatic logic [31:0] modelResult();
        int unsigned value;
        int unsigned mem;
        mem = inMemData;
        if (!inMemToReg) return inAluResult;
        if (inLoadSize == 2'b10) begin
            value = (mem >> (8 * int'(inByteOffset))) & 32'hFF;
            if (inLoadSigned && value >= 32'h80) value = value + 32'hFFFF_FF00;
        end else if (inLoadSize == 2'b01) begin
            value = (mem >> (8 * (int'(inByteOffset) & 2))) & 32'hFFFF;
            if (inLoadSigned && value >= 32'h8000) value = value + 32'hFFFF_0000;
        end else begin
            value = mem;
        end
        return value;
    endfunction

    task automatic setIdle();
        inValid = 0; inRegWrite = 0; inDest = 0; inMemToReg = 0;
        inLoadSize = 0; inLoadSigned = 0; inByteOffset = 0;
        inAluResult = 0; inMemData = 0; flush = 0; portGrant = 0; rst = 0;
    endtask

    task automatic setAlu(input logic [4:0] dest, input logic [31:0] alu);
        inValid = 1; inRegWrite = 1; inDest = dest; inMemToReg = 0; inAluResult = alu;
    endtask

    task automatic setLoad(input logic [4:0] dest, input logic [1:0] size, input logic sgn,
                           input logic [1:0] off, input logic [31:0] mem);
        inValid = 1; inRegWrite = 1; inDest = dest; inMemToReg = 1;
        inLoadSize = size; inLoadSigned = sgn; inByteOffset = off; inMemData = mem;
    endtask

    // One clock: compare outputs with the model mid-cycle, then advance the model.
    task automatic doCycle();
        bit          expReady;
        bit          doPush;
        bit          doPop;
        logic [31:0] newData;
        int          depth;
        @(negedge clk);
        depth    = modelDest.size();
        expReady = (depth < 2) && !flush;
        checkEq("inReady", {31'b0, inReady}, {31'b0, expReady});
        checkEq("count", {30'b0, count}, 32'(depth));
        checkEq("writeEnable", {31'b0, writeEnable}, {31'b0, depth == 0});
        checkEq("writeAddr", {27'b0, writeAddr}, depth == 0 ? 32'd0 : {27'b0, modelDest[0]});
        checkEq("writeData", writeData, depth == 0 ? 32'd0 : modelData[0]);
        doPush  = inValid && expReady && inRegWrite && inDest != 0;
        doPop   = depth > 0 && portGrant && !flush;
        newData = modelResult();
        @(posedge clk);
        if (rst || flush) begin
            modelDest.delete();
            modelData.delete();
        end else begin
            if (doPop) begin
                void'(modelDest.pop_front());
                void'(modelData.pop_front());
            end
            if (doPush) begin
                modelDest.push_back(inDest);
                modelData.push_back(newData);
            end
        end
        #1;
    endtask

    initial begin
        setIdle();
        rst = 1;
        doCycle();
        doCycle();
        rst = 0;
        #1;
        checkEq("reset_we", {31'b0, writeEnable}, 32'd1);
        checkEq("reset_addr", {27'b0, writeAddr}, 32'd0);
        checkEq("reset_data", writeData, 32'd0);
        checkEq("reset_count", {30'b0, count}, 32'd0);
        checkEq("reset_ready", {31'b0, inReady}, 32'd1);

        // Single ALU write, latency 1, then drains.
        setAlu(5'd5, 32'h1234_5678); portGrant = 1;
        doCycle();
        setIdle(); portGrant = 1;
        checkEq("alu_we", {31'b0, writeEnable}, 32'd0);
        checkEq("alu_addr", {27'b0, writeAddr}, 32'd5);
        checkEq("alu_data", writeData, 32'h1234_5678);
        doCycle();
        checkEq("alu_drained", {30'b0, count}, 32'd0);

        // Load extraction cases with no grant so each lands at the head.
        setIdle(); setLoad(5'd7, 2'b10, 1'b1, 2'd3, 32'h80FF_0000);
        doCycle();
        checkEq("lb_signed", writeData, 32'hFFFF_FF80);
        setIdle(); portGrant = 1; doCycle();
        setIdle(); setLoad(5'd7, 2'b10, 1'b0, 2'd3, 32'h80FF_0000);
        doCycle();
        checkEq("lb_unsigned", writeData, 32'h0000_0080);
        setIdle(); portGrant = 1; doCycle();
        setIdle(); setLoad(5'd7, 2'b01, 1'b1, 2'd2, 32'h80FF_0000);
        doCycle();
        checkEq("lh_signed", writeData, 32'hFFFF_80FF);
        setIdle(); portGrant = 1; doCycle();

        // Back-pressure: three offers with no grant, then drain in order.
        setIdle(); setAlu(5'd1, 32'h11); doCycle();
        setAlu(5'd2, 32'h22); doCycle();
        setAlu(5'd3, 32'h33);
        checkEq("full_count", {30'b0, count}, 32'd2);
        checkEq("full_ready", {31'b0, inReady}, 32'd0);
        doCycle(); doCycle();
        checkEq("stall_head", {27'b0, writeAddr}, 32'd1);
        portGrant = 1; doCycle();
        checkEq("order_2", {27'b0, writeAddr}, 32'd2);
        doCycle();
        checkEq("order_3", {27'b0, writeAddr}, 32'd3);
        setIdle(); portGrant = 1; doCycle();
        checkEq("order_done", {30'b0, count}, 32'd0);

        // Simultaneous push and pop with one entry held.
        setIdle(); setAlu(5'd9, 32'h99); doCycle();
        setAlu(5'd10, 32'hAA); portGrant = 1; doCycle();
        checkEq("pushpop_count", {30'b0, count}, 32'd1);
        checkEq("pushpop_addr", {27'b0, writeAddr}, 32'd10);
        setIdle(); portGrant = 1; doCycle();

        // Flush with a full buffer and a live offer.
        setIdle(); setAlu(5'd4, 32'h44); doCycle(); doCycle();
        flush = 1; portGrant = 1; setAlu(5'd6, 32'h66); doCycle();
        setIdle();
        checkEq("flush_count", {30'b0, count}, 32'd0);
        checkEq("flush_we", {31'b0, writeEnable}, 32'd1);

        // Discarded offers: dest 0 and regWrite 0.
        setAlu(5'd0, 32'h55); doCycle();
        setAlu(5'd8, 32'h55); inRegWrite = 0; doCycle();
        setIdle();
        checkEq("discard_we", {31'b0, writeEnable}, 32'd1);

        // Same destination twice is two separate entries.
        setAlu(5'd12, 32'h1); doCycle();
        setAlu(5'd12, 32'h2); doCycle();
        setIdle();
        checkEq("nomerge_count", {30'b0, count}, 32'd2);

        // Reset mid-operation drops everything.
        rst = 1; portGrant = 1; doCycle();
        rst = 0; portGrant = 0;
        checkEq("midrst_we", {31'b0, writeEnable}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            setIdle();
            rst          = ($urandom_range(0, 79) == 0);
            flush        = ($urandom_range(0, 24) == 0);
            portGrant    = ($urandom_range(0, 9) < 6);
            inValid      = ($urandom_range(0, 9) < 7);
            inRegWrite   = ($urandom_range(0, 9) < 9);
            inDest       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            inMemToReg   = 1'($urandom);
            inLoadSize   = 2'($urandom);
            inLoadSigned = 1'($urandom);
            inByteOffset = 2'($urandom);
            inAluResult  = $urandom;
            inMemData    = $urandom;
            doCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
